mmio_io_ctrl: RTL

MMIO_IO_CTRL -- requirements
Module: mmio_io_ctrl

---
 rtl/mmio_io_ctrl_if.sv | 21 ++
 rtl/mmio_io_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mmio_io_ctrl_if.sv
// rtl/mmio_io_ctrl_if.sv - processor/RAM data-bus bundle for the MMIO I/O controller
//
// Purpose: groups the processor data-port signals seen by the I/O block.
// Ports (signals):
//   addr   - processor data word address
//   wren   - processor store strobe
//   wdata  - processor store data
//   mem_q  - RAM read data, passed through when the address is not an I/O register
//   q_out  - read data returned to the processor
//   io_hit - address falls in the I/O register window
interface mmio_io_ctrl_if;
    logic [31:0] addr;
    logic        wren;
    logic [31:0] wdata;
    logic [31:0] mem_q;
    logic [31:0] q_out;
    logic        io_hit;

    modport master (output addr, wren, wdata, mem_q, input q_out, io_hit);
    modport slave  (input addr, wren, wdata, mem_q, output q_out, io_hit);
endinterface

// File: rtl/mmio_io_ctrl.sv
// rtl/mmio_io_ctrl.sv - memory-mapped switch/button/LED controller with debounce and press counting
//
// Purpose: five-word I/O register window at BASE_ADDR:
//   +0 SW (RO), +1 LED (RW), +2 BTN_LEVEL (RO), +3 BTN_EVENT (W1C), +4 PRESS_COUNT (RO, write clears).
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset
//   bus    - processor data port (addr/wren/wdata/mem_q in, q_out/io_hit out)
//   sw     - asynchronous switch inputs
//   btn    - asynchronous push-button inputs
//   led    - registered LED drive
module mmio_io_ctrl #(
    parameter int unsigned BASE_ADDR       = 4096,
    parameter int unsigned SW_WIDTH        = 16,
    parameter int unsigned BTN_COUNT       = 4,
    parameter int unsigned LED_WIDTH       = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 400000
) (
    input  logic                 clock,
    input  logic                 reset,
    mmio_io_ctrl_if.slave        bus,
    input  logic [SW_WIDTH-1:0]  sw,
    input  logic [BTN_COUNT-1:0] btn,
    output logic [LED_WIDTH-1:0] led
);
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]      BASE     = 32'(BASE_ADDR);

    // Two-flop synchronisers
    logic [SW_WIDTH-1:0]  sw_s1_q, sw_s2_q;
    logic [BTN_COUNT-1:0] btn_s1_q, btn_s2_q;

    // Debouncer state
    logic [CNT_W-1:0]     db_cnt_q [BTN_COUNT];
    logic [CNT_W-1:0]     db_cnt_d [BTN_COUNT];
    logic [BTN_COUNT-1:0] db_lvl_q, db_lvl_d;
    logic [BTN_COUNT-1:0] press;
    logic [4:0]           n_press;

    // Register state
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [BTN_COUNT-1:0] ev_q, ev_d;
    logic [15:0]          pc_q, pc_d;

    // Address decode
    logic [31:0] offset;
    logic        hit;
    logic        wr_led, wr_ev, wr_pc;
    logic [BTN_COUNT-1:0] ev_clr;
    logic [16:0] pc_sum;
    logic [31:0] rd;
    logic        unused_wdata;

    assign offset = bus.addr - BASE;
    // The lower-bound test keeps addresses below BASE (which wrap to huge offsets) out of the window.
    assign hit    = (bus.addr >= BASE) && (offset <= 32'd4);

    assign wr_led = bus.wren && hit && (offset[2:0] == 3'd1);
    assign wr_ev  = bus.wren && hit && (offset[2:0] == 3'd3);
    assign wr_pc  = bus.wren && hit && (offset[2:0] == 3'd4);

    assign unused_wdata = ^bus.wdata;

    // Debounce: a level flips only after the synchronised input has disagreed with it
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_comb begin
        db_lvl_d = db_lvl_q;
        press    = '0;
        n_press  = '0;
        for (int i = 0; i < int'(BTN_COUNT); i++) begin
            db_cnt_d[i] = '0;
            if (btn_s2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == CNT_LAST) begin
                    db_lvl_d[i] = ~db_lvl_q[i];
                    press[i]    = ~db_lvl_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                end
            end
            n_press = n_press + 5'(press[i]);
        end
    end

    always_comb begin
        led_d  = wr_led ? bus.wdata[LED_WIDTH-1:0] : led_q;
        ev_clr = wr_ev ? bus.wdata[BTN_COUNT-1:0] : '0;
        // Set after clear so a press on the same edge as a clearing write survives.
        ev_d   = (ev_q & ~ev_clr) | press;
        pc_sum = {1'b0, pc_q} + 17'(n_press);
        if (wr_pc) begin
            pc_d = '0;
        end else if (pc_sum[16]) begin
            pc_d = 16'hFFFF;
        end else begin
            pc_d = pc_sum[15:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            db_cnt_q <= '{default: '0};
            db_lvl_q <= '0;
            led_q    <= '0;
            ev_q     <= '0;
            pc_q     <= '0;
        end else begin
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
            led_q    <= led_d;
            ev_q     <= ev_d;
            pc_q     <= pc_d;
        end
    end

    // Read mux is purely combinational and side-effect free.
    always_comb begin
        rd = '0;
        case (offset[2:0])
            3'd0:    rd[SW_WIDTH-1:0]  = sw_s2_q;
            3'd1:    rd[LED_WIDTH-1:0] = led_q;
            3'd2:    rd[BTN_COUNT-1:0] = db_lvl_q;
            3'd3:    rd[BTN_COUNT-1:0] = ev_q;
            3'd4:    rd[15:0]          = pc_q;
            default: rd = '0;
        endcase
    end

    assign bus.q_out  = hit ? rd : bus.mem_q;
    assign bus.io_hit = hit;
    assign led        = led_q;
endmodule
